hazard_ctrl_tn: RTL and testbench

// - Parametrised Tuse/Tnew stall and forward-select controller for the 5-stage MIPS core.

---
 rtl/hazard_ctrl_tn_pkg.sv | 25 ++
 rtl/hazard_ctrl_tn_if.sv | 37 +++
 rtl/hz_stage_reg.sv | 66 ++++++
 rtl/hazard_ctrl_tn.sv | 114 +++++++++++
 tb/tb_hazard_ctrl_tn.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_tn_pkg.sv
// Shared constants, forward-select encodings and helpers for the Tuse/Tnew hazard controller.
package hazard_ctrl_tn_pkg;

    localparam int unsigned REG_AW_DEF  = 5;
    localparam int unsigned NSRC_DEF    = 2;
    localparam int unsigned TW_DEF      = 2;
    localparam int unsigned NSTG_DEF    = 3;
    localparam int unsigned MUL_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF = 10;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned FSEL_W      = 2;

    typedef enum logic [FSEL_W-1:0] {
        FWD_RF  = 2'd0,
        FWD_STE = 2'd1,
        FWD_STM = 2'd2,
        FWD_STW = 2'd3
    } fwd_sel_e;

    // Stage index k (0 = E) forwards with code k+1.
    function automatic fwd_sel_e fwd_code(input int unsigned stg);
        return fwd_sel_e'(FSEL_W'(stg + 1));
    endfunction

endpackage

// File: rtl/hazard_ctrl_tn_if.sv
// D-stage hazard request bundle and the stall/forward responses of the controller.
interface hazard_ctrl_tn_if #(
    parameter int unsigned REG_AW = hazard_ctrl_tn_pkg::REG_AW_DEF,
    parameter int unsigned NSRC   = hazard_ctrl_tn_pkg::NSRC_DEF,
    parameter int unsigned TW     = hazard_ctrl_tn_pkg::TW_DEF,
    parameter int unsigned CNT_W  = hazard_ctrl_tn_pkg::CNT_W_DEF
);
    logic [NSRC*REG_AW-1:0] src_addr_D;
    logic [NSRC-1:0]        src_vld_D;
    logic [NSRC*TW-1:0]     tuse_D;
    logic [REG_AW-1:0]      a3_D;
    logic [TW-1:0]          tnew_D;
    logic                   md_start_D;
    logic                   md_div_D;
    logic                   md_use_D;
    logic                   eret_D;
    logic                   mtepc_D;
    logic                   flush;
    logic                   en_pc;
    logic                   en_d;
    logic                   clr_e;
    logic [NSRC*hazard_ctrl_tn_pkg::FSEL_W-1:0] fwd_sel;
    logic                   md_busy;
    logic [CNT_W-1:0]       stall_cnt;

    modport master (
        output src_addr_D, src_vld_D, tuse_D, a3_D, tnew_D,
               md_start_D, md_div_D, md_use_D, eret_D, mtepc_D, flush,
        input  en_pc, en_d, clr_e, fwd_sel, md_busy, stall_cnt
    );

    modport slave (
        input  src_addr_D, src_vld_D, tuse_D, a3_D, tnew_D,
               md_start_D, md_div_D, md_use_D, eret_D, mtepc_D, flush,
        output en_pc, en_d, clr_e, fwd_sel, md_busy, stall_cnt
    );
endinterface

// File: rtl/hz_stage_reg.sv
// One shadow pipeline stage: destination, remaining Tnew and mult/div/EPC flags.
module hz_stage_reg
    import hazard_ctrl_tn_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned TW       = TW_DEF,
    parameter bit          DEC_TNEW = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_i,
    input  logic [REG_AW-1:0] a3_i,
    input  logic [TW-1:0]     tnew_i,
    input  logic              mtepc_i,
    input  logic              mds_i,
    input  logic              mdd_i,
    output logic [REG_AW-1:0] a3_o,
    output logic [TW-1:0]     tnew_o,
    output logic              mtepc_o,
    output logic              mds_o,
    output logic              mdd_o
);
    logic [REG_AW-1:0] a3_q, a3_d;
    logic [TW-1:0]     tnew_q, tnew_d;
    logic              mtepc_q, mtepc_d;
    logic              mds_q, mds_d;
    logic              mdd_q, mdd_d;

    // Invalid input loads a bubble; tnew counts down to zero as the instruction ages.
    always_comb begin
        a3_d    = '0;
        tnew_d  = '0;
        mtepc_d = 1'b0;
        mds_d   = 1'b0;
        mdd_d   = 1'b0;
        if (vld_i) begin
            a3_d    = a3_i;
            tnew_d  = (DEC_TNEW && (tnew_i != '0)) ? tnew_i - TW'(1) : tnew_i;
            mtepc_d = mtepc_i;
            mds_d   = mds_i;
            mdd_d   = mdd_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a3_q    <= '0;
            tnew_q  <= '0;
            mtepc_q <= 1'b0;
            mds_q   <= 1'b0;
            mdd_q   <= 1'b0;
        end else begin
            a3_q    <= a3_d;
            tnew_q  <= tnew_d;
            mtepc_q <= mtepc_d;
            mds_q   <= mds_d;
            mdd_q   <= mdd_d;
        end
    end

    assign a3_o    = a3_q;
    assign tnew_o  = tnew_q;
    assign mtepc_o = mtepc_q;
    assign mds_o   = mds_q;
    assign mdd_o   = mdd_q;
endmodule

// File: rtl/hazard_ctrl_tn.sv
// Tuse/Tnew stall and forward-select controller with mult/div busy tracking and EPC interlock.
module hazard_ctrl_tn
    import hazard_ctrl_tn_pkg::*;
#(
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned NSRC    = NSRC_DEF,
    parameter int unsigned TW      = TW_DEF,
    parameter int unsigned NSTG    = NSTG_DEF,
    parameter int unsigned MUL_CYC = MUL_CYC_DEF,
    parameter int unsigned DIV_CYC = DIV_CYC_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input logic             clk,
    input logic             rst_n,
    hazard_ctrl_tn_if.slave hz_if
);
    localparam int unsigned MD_MAX = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
    localparam int unsigned MDW    = $clog2(MD_MAX + 1);

    logic [REG_AW-1:0] a3_q    [NSTG];
    logic [TW-1:0]     tnew_q  [NSTG];
    logic              mtepc_q [NSTG];
    logic              mds_q   [NSTG];
    logic              mdd_q   [NSTG];

    logic [MDW-1:0]    md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [NSRC-1:0]   op_stall_c;
    logic [NSRC*FSEL_W-1:0] fwd_sel_c;
    logic md_busy_c, md_stall_c, epc_near_c, epc_stall_c, stall_c;

    for (genvar k = 0; k < int'(NSTG); k++) begin : g_stg
        if (k == 0) begin : g_e
            hz_stage_reg #(.REG_AW(REG_AW), .TW(TW), .DEC_TNEW(1'b0)) u_stg (
                .clk(clk), .rst_n(rst_n), .vld_i(~stall_c & ~hz_if.flush),
                .a3_i(hz_if.a3_D), .tnew_i(hz_if.tnew_D), .mtepc_i(hz_if.mtepc_D),
                .mds_i(hz_if.md_start_D), .mdd_i(hz_if.md_div_D),
                .a3_o(a3_q[k]), .tnew_o(tnew_q[k]), .mtepc_o(mtepc_q[k]),
                .mds_o(mds_q[k]), .mdd_o(mdd_q[k])
            );
        end else begin : g_n
            hz_stage_reg #(.REG_AW(REG_AW), .TW(TW), .DEC_TNEW(1'b1)) u_stg (
                .clk(clk), .rst_n(rst_n), .vld_i(1'b1),
                .a3_i(a3_q[k-1]), .tnew_i(tnew_q[k-1]), .mtepc_i(mtepc_q[k-1]),
                .mds_i(mds_q[k-1]), .mdd_i(mdd_q[k-1]),
                .a3_o(a3_q[k]), .tnew_o(tnew_q[k]), .mtepc_o(mtepc_q[k]),
                .mds_o(mds_q[k]), .mdd_o(mdd_q[k])
            );
        end
    end

    // Walk oldest to youngest so the youngest matching stage overrides.
    always_comb begin
        op_stall_c = '0;
        fwd_sel_c  = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            for (int k = int'(NSTG) - 1; k >= 0; k--) begin
                if (hz_if.src_vld_D[i] &&
                    (hz_if.src_addr_D[i*REG_AW +: REG_AW] != '0) &&
                    (hz_if.src_addr_D[i*REG_AW +: REG_AW] == a3_q[k])) begin
                    fwd_sel_c[i*FSEL_W +: FSEL_W] = fwd_code(unsigned'(k));
                    op_stall_c[i] = (hz_if.tuse_D[i*TW +: TW] < tnew_q[k]);
                end
            end
        end
    end

    // eret must wait until an in-flight mtc0 EPC has reached W.
    always_comb begin
        epc_near_c = 1'b0;
        for (int k = 0; (k < int'(NSTG)) && (k < 2); k++) begin
            epc_near_c = epc_near_c | mtepc_q[k];
        end
    end

    // A flushed md_start never loads; a count already running is not aborted.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (mds_q[0] && !hz_if.flush) begin
            md_cnt_d = mdd_q[0] ? MDW'(DIV_CYC) : MDW'(MUL_CYC);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MDW'(1);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && !hz_if.flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_busy_c   = mds_q[0] | (md_cnt_q != '0);
    assign md_stall_c  = hz_if.md_use_D & md_busy_c;
    assign epc_stall_c = hz_if.eret_D & epc_near_c;
    assign stall_c     = (|op_stall_c) | md_stall_c | epc_stall_c;

    assign hz_if.en_pc     = ~stall_c | hz_if.flush;
    assign hz_if.en_d      = ~stall_c | hz_if.flush;
    assign hz_if.clr_e     = stall_c | hz_if.flush;
    assign hz_if.fwd_sel   = fwd_sel_c;
    assign hz_if.md_busy   = md_busy_c;
    assign hz_if.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl_tn.sv
// Directed per-cycle vectors for hazard_ctrl_tn, plus a CNT_W=4 twin for saturation.
module tb_hazard_ctrl_tn;
    localparam logic [5:0] C_MDS  = 6'b100000;
    localparam logic [5:0] C_MDD  = 6'b010000;
    localparam logic [5:0] C_MDU  = 6'b001000;
    localparam logic [5:0] C_ERET = 6'b000100;
    localparam logic [5:0] C_EPC  = 6'b000010;
    localparam logic [5:0] C_FL   = 6'b000001;

    typedef struct {
        logic [4:0] s0;
        logic [4:0] s1;
        logic [1:0] vld;
        logic [1:0] tu0;
        logic [1:0] tu1;
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [5:0] ctl;
        logic       en;
        logic       clr;
        logic [3:0] fwd;
        logic       busy;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   exp_cnt;
    vec_t vecs[$];

    hazard_ctrl_tn_if #(.CNT_W(16)) bus ();
    hazard_ctrl_tn_if #(.CNT_W(4))  bus4 ();

    assign bus4.src_addr_D = bus.src_addr_D;
    assign bus4.src_vld_D  = bus.src_vld_D;
    assign bus4.tuse_D     = bus.tuse_D;
    assign bus4.a3_D       = bus.a3_D;
    assign bus4.tnew_D     = bus.tnew_D;
    assign bus4.md_start_D = bus.md_start_D;
    assign bus4.md_div_D   = bus.md_div_D;
    assign bus4.md_use_D   = bus.md_use_D;
    assign bus4.eret_D     = bus.eret_D;
    assign bus4.mtepc_D    = bus.mtepc_D;
    assign bus4.flush      = bus.flush;

    hazard_ctrl_tn #(.CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .hz_if(bus));
    hazard_ctrl_tn #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .hz_if(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] vld,
                               input logic [1:0] tu0, input logic [1:0] tu1, input logic [4:0] a3,
                               input logic [1:0] tnew, input logic [5:0] ctl, input logic en,
                               input logic clr, input logic [3:0] fwd, input logic busy);
        vec_t t;
        t.s0 = s0; t.s1 = s1; t.vld = vld; t.tu0 = tu0; t.tu1 = tu1;
        t.a3 = a3; t.tnew = tnew; t.ctl = ctl;
        t.en = en; t.clr = clr; t.fwd = fwd; t.busy = busy;
        return t;
    endfunction

    task automatic rep(input int n, input vec_t t);
        for (int i = 0; i < n; i++) vecs.push_back(t);
    endtask

    task automatic drive(input vec_t t);
        bus.src_addr_D = {t.s1, t.s0};
        bus.src_vld_D  = t.vld;
        bus.tuse_D     = {t.tu1, t.tu0};
        bus.a3_D       = t.a3;
        bus.tnew_D     = t.tnew;
        {bus.md_start_D, bus.md_div_D, bus.md_use_D, bus.eret_D, bus.mtepc_D, bus.flush} = t.ctl;
    endtask

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic chk_reset(input int row);
        chk("rst_en_pc", row, 16'(bus.en_pc), 16'h1);
        chk("rst_en_d", row, 16'(bus.en_d), 16'h1);
        chk("rst_clr_e", row, 16'(bus.clr_e), 16'h0);
        chk("rst_fwd", row, 16'(bus.fwd_sel), 16'h0);
        chk("rst_busy", row, 16'(bus.md_busy), 16'h0);
        chk("rst_cnt", row, 16'(bus.stall_cnt), 16'h0);
        chk("rst_cnt4", row, 16'(bus4.stall_cnt), 16'h0);
    endtask

    initial begin
        vec_t nop_v, div_v, mfhi_v;
        n_chk = 0; n_err = 0; exp_cnt = 0;
        nop_v  = v(0, 0, 2'b00, 0, 0, 0, 0, 6'b0, 1, 0, 4'h0, 0);
        div_v  = v(17, 18, 2'b00, 1, 1, 0, 0, C_MDS | C_MDD | C_MDU, 1, 0, 4'h0, 0);
        mfhi_v = v(0, 0, 2'b00, 0, 0, 8, 1, C_MDU, 1, 0, 4'h0, 0);

        // lw $t1 (tnew 2) then addu reading $t1 at tuse 0
        vecs.push_back(v(16, 17, 2'b01, 1, 1, 9, 2, 6'b0, 1, 0, 4'h0, 0));
        vecs.push_back(v(9, 0, 2'b11, 0, 0, 10, 1, 6'b0, 0, 1, 4'h1, 0));
        vecs.push_back(v(9, 0, 2'b11, 0, 0, 10, 1, 6'b0, 0, 1, 4'h2, 0));
        vecs.push_back(v(9, 0, 2'b11, 0, 0, 10, 1, 6'b0, 1, 0, 4'h3, 0));
        // addu $t1 (tnew 1) then beq tuse 0, then again with tuse 1
        vecs.push_back(v(17, 18, 2'b11, 1, 1, 9, 1, 6'b0, 1, 0, 4'h0, 0));
        vecs.push_back(v(9, 0, 2'b11, 0, 0, 0, 0, 6'b0, 0, 1, 4'h1, 0));
        vecs.push_back(v(9, 0, 2'b11, 0, 0, 0, 0, 6'b0, 1, 0, 4'h2, 0));
        vecs.push_back(v(17, 18, 2'b11, 1, 1, 9, 1, 6'b0, 1, 0, 4'h0, 0));
        vecs.push_back(v(9, 0, 2'b11, 1, 0, 0, 0, 6'b0, 1, 0, 4'h1, 0));
        // $t1 live in both E and W: youngest (E) must win for operand 1
        vecs.push_back(v(17, 18, 2'b11, 1, 1, 9, 1, 6'b0, 1, 0, 4'h0, 0));
        vecs.push_back(v(0, 9, 2'b10, 0, 0, 0, 0, 6'b0, 0, 1, 4'h4, 0));
        vecs.push_back(v(0, 9, 2'b10, 0, 0, 0, 0, 6'b0, 1, 0, 4'h8, 0));
        // div then mfhi: 11 busy cycles
        vecs.push_back(div_v);
        rep(11, v(0, 0, 2'b00, 0, 0, 8, 1, C_MDU, 0, 1, 4'h0, 1));
        vecs.push_back(mfhi_v);
        // mtc0 EPC then eret: two stall cycles
        vecs.push_back(v(0, 19, 2'b10, 0, 2, 0, 0, C_EPC, 1, 0, 4'h0, 0));
        rep(2, v(0, 0, 2'b00, 0, 0, 0, 0, C_ERET, 0, 1, 4'h0, 0));
        vecs.push_back(v(0, 0, 2'b00, 0, 0, 0, 0, C_ERET, 1, 0, 4'h0, 0));
        // flush during eret stall wins
        vecs.push_back(v(0, 19, 2'b10, 0, 2, 0, 0, C_EPC, 1, 0, 4'h0, 0));
        vecs.push_back(v(0, 0, 2'b00, 0, 0, 0, 0, C_ERET | C_FL, 1, 1, 4'h0, 0));
        vecs.push_back(v(0, 0, 2'b00, 0, 0, 0, 0, C_ERET, 0, 1, 4'h0, 0));
        vecs.push_back(v(0, 0, 2'b00, 0, 0, 0, 0, C_ERET, 1, 0, 4'h0, 0));
        // flushed producer leaves a bubble in E
        vecs.push_back(v(17, 18, 2'b11, 1, 1, 11, 1, C_FL, 1, 1, 4'h0, 0));
        vecs.push_back(v(11, 0, 2'b01, 0, 0, 0, 0, 6'b0, 1, 0, 4'h0, 0));
        // register 0 never matches, even against a3=0 with live tnew
        vecs.push_back(v(17, 18, 2'b00, 0, 0, 0, 2, 6'b0, 1, 0, 4'h0, 0));
        rep(2, v(0, 0, 2'b11, 0, 0, 0, 2, 6'b0, 1, 0, 4'h0, 0));
        // mult then mfhi: 6 busy cycles
        vecs.push_back(v(0, 0, 2'b00, 0, 0, 0, 0, C_MDS | C_MDU, 1, 0, 4'h0, 0));
        rep(6, v(0, 0, 2'b00, 0, 0, 8, 1, C_MDU, 0, 1, 4'h0, 1));
        vecs.push_back(mfhi_v);
        // md_start flushed in E never loads the counter
        vecs.push_back(v(0, 0, 2'b00, 0, 0, 0, 0, C_MDS | C_MDU, 1, 0, 4'h0, 0));
        vecs.push_back(v(0, 0, 2'b00, 0, 0, 0, 0, C_FL, 1, 1, 4'h0, 1));
        vecs.push_back(mfhi_v);

        rst_n = 1'b0;
        drive(nop_v);
        #3;
        chk_reset(-1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            chk("en_pc", i, 16'(bus.en_pc), 16'(vecs[i].en));
            chk("en_d", i, 16'(bus.en_d), 16'(vecs[i].en));
            chk("clr_e", i, 16'(bus.clr_e), 16'(vecs[i].clr));
            chk("fwd_sel", i, 16'(bus.fwd_sel), 16'(vecs[i].fwd));
            chk("md_busy", i, 16'(bus.md_busy), 16'(vecs[i].busy));
            chk("stall_cnt", i, 16'(bus.stall_cnt), 16'(exp_cnt));
            chk("stall_cnt4", i, 16'(bus4.stall_cnt), 16'((exp_cnt > 15) ? 15 : exp_cnt));
            chk("en_pc4", i, 16'(bus4.en_pc), 16'(vecs[i].en));
            if (vecs[i].clr && !vecs[i].ctl[0]) exp_cnt++;
        end

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        drive(div_v);
        @(negedge clk);
        drive(mfhi_v);
        repeat (3) @(negedge clk);
        #2;
        chk("mid_div_busy", 100, 16'(bus.md_busy), 16'h1);
        chk("mid_div_en_pc", 100, 16'(bus.en_pc), 16'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset(101);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("post_rst_busy", 102, 16'(bus.md_busy), 16'h0);
        chk("post_rst_en_pc", 102, 16'(bus.en_pc), 16'h1);
        chk("post_rst_cnt", 102, 16'(bus.stall_cnt), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
